message_ctrl: RTL and testbench



---
 rtl/message_ctrl.sv | 152 +++++++++++++++
 tb/tb_message_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/message_ctrl.sv
// Message RAM sequencer: collects rx bytes into RAM, then replays the
// stored characters to the UART transmitter, optionally ending with CR/LF.
module message_ctrl #(
    parameter int unsigned MSG_BYTES = 3,
    parameter int unsigned RD_LEN    = 8,
    parameter bit          EOL_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       new_rx_data,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       ram_clr,
    output logic [3:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    input  logic       tx_busy,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [2:0] {
        COLLECT, FETCH, WAIT, SEND, GAP, CR, LF, CLEAR
    } state_t;

    // GAP is shared by the character, CR and LF strobes
    typedef enum logic [1:0] {
        G_CHAR, G_CR, G_LF
    } gap_t;

    localparam logic [3:0] LAST_WR = 4'(MSG_BYTES - 1);
    localparam logic [3:0] RD_END  = 4'(RD_LEN);

    state_t     state_q;
    gap_t       gap_q;
    logic [3:0] wr_cnt_q;
    logic [3:0] rd_idx_q;
    logic       wr_en_q;
    logic [3:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic       ram_clr_q;
    logic [3:0] rd_addr_q;
    logic [7:0] tx_data_q;
    logic       new_tx_q;
    logic       busy_q;
    logic       overrun_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= COLLECT;
            gap_q     <= G_CHAR;
            wr_cnt_q  <= '0;
            rd_idx_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ram_clr_q <= 1'b0;
            rd_addr_q <= '0;
            tx_data_q <= '0;
            new_tx_q  <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_en_q   <= 1'b0;
            new_tx_q  <= 1'b0;
            ram_clr_q <= 1'b0;
            if (new_rx_data && state_q != COLLECT) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                COLLECT: begin
                    if (new_rx_data) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= wr_cnt_q;
                        wr_data_q <= rx_data;
                        if (wr_cnt_q == LAST_WR) begin
                            wr_cnt_q <= '0;
                            rd_idx_q <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= FETCH;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 4'd1;
                        end
                    end
                end
                FETCH: begin
                    rd_addr_q <= rd_idx_q;
                    state_q   <= WAIT;
                end
                WAIT: state_q <= SEND;
                SEND: begin
                    if (!tx_busy) begin
                        tx_data_q <= rd_data;
                        new_tx_q  <= 1'b1;
                        rd_idx_q  <= rd_idx_q + 4'd1;
                        gap_q     <= G_CHAR;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    case (gap_q)
                        G_CHAR: begin
                            if (rd_idx_q == RD_END) begin
                                state_q <= EOL_EN ? CR : CLEAR;
                            end else begin
                                state_q <= FETCH;
                            end
                        end
                        G_CR:    state_q <= LF;
                        default: state_q <= CLEAR;
                    endcase
                end
                CR: begin
                    if (!tx_busy) begin
                        tx_data_q <= 8'h0D;
                        new_tx_q  <= 1'b1;
                        gap_q     <= G_CR;
                        state_q   <= GAP;
                    end
                end
                LF: begin
                    if (!tx_busy) begin
                        tx_data_q <= 8'h0A;
                        new_tx_q  <= 1'b1;
                        gap_q     <= G_LF;
                        state_q   <= GAP;
                    end
                end
                CLEAR: begin
                    ram_clr_q <= 1'b1;
                    rd_addr_q <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= COLLECT;
                end
            endcase
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign ram_clr     = ram_clr_q;
    assign rd_addr     = rd_addr_q;
    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_message_ctrl.sv
// Directed bench for message_ctrl: default build plus a
// single-byte, four-character, no-EOL build.
module tb_message_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // default build
    logic [7:0] rx1 = '0;
    logic       nrx1 = 1'b0;
    logic       txb1 = 1'b0;
    logic [7:0] rd1;
    logic       wen1, clr1, ntx1, busy1, ovr1;
    logic [3:0] wa1, ra1;
    logic [7:0] wd1, tx1;

    // MSG_BYTES=1, RD_LEN=4, EOL_EN=0 build
    logic [7:0] rx2 = '0;
    logic       nrx2 = 1'b0;
    logic       txb2 = 1'b0;
    logic [7:0] rd2;
    logic       wen2, clr2, ntx2, busy2, ovr2;
    logic [3:0] wa2, ra2;
    logic [7:0] wd2, tx2;

    message_ctrl dut1 (
        .clk(clk), .rst(rst),
        .rx_data(rx1), .new_rx_data(nrx1),
        .wr_en(wen1), .wr_addr(wa1), .wr_data(wd1),
        .ram_clr(clr1), .rd_addr(ra1), .rd_data(rd1),
        .tx_data(tx1), .new_tx_data(ntx1),
        .tx_busy(txb1), .busy(busy1), .overrun(ovr1)
    );

    message_ctrl #(
        .MSG_BYTES(1), .RD_LEN(4), .EOL_EN(1'b0)
    ) dut2 (
        .clk(clk), .rst(rst),
        .rx_data(rx2), .new_rx_data(nrx2),
        .wr_en(wen2), .wr_addr(wa2), .wr_data(wd2),
        .ram_clr(clr2), .rd_addr(ra2), .rd_data(rd2),
        .tx_data(tx2), .new_tx_data(ntx2),
        .tx_busy(txb2), .busy(busy2), .overrun(ovr2)
    );

    // registered-read RAM models with known background contents
    logic [7:0] ram1 [16] = '{8'h00, 8'h00, 8'h00, 8'h63,
                              8'h64, 8'h65, 8'h66, 8'h67,
                              8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] ram2 [16] = '{8'h00, 8'h11, 8'h22, 8'h33,
                              8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00};

    always @(posedge clk) begin
        if (clr1) begin
            for (int i = 0; i < 16; i++) ram1[i] <= 8'h00;
        end else if (wen1) begin
            ram1[wa1] <= wd1;
        end
        rd1 <= ram1[ra1];
    end

    always @(posedge clk) begin
        if (clr2) begin
            for (int i = 0; i < 16; i++) ram2[i] <= 8'h00;
        end else if (wen2) begin
            ram2[wa2] <= wd2;
        end
        rd2 <= ram2[ra2];
    end

    // observation: strobed bytes, read address, clear pulses, spacing
    logic [7:0] txq1[$];
    logic [3:0] rdq1[$];
    logic [7:0] txq2[$];
    int clrs1 = 0;
    int clrs2 = 0;
    int space_err = 0;
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;

    always @(negedge clk) begin
        if (ntx1) begin
            txq1.push_back(tx1);
            rdq1.push_back(ra1);
            if (prev1 || txb1) space_err++;
        end
        if (ntx2) begin
            txq2.push_back(tx2);
            if (prev2 || txb2) space_err++;
        end
        if (clr1) clrs1++;
        if (clr2) clrs2++;
        prev1 = ntx1;
        prev2 = ntx2;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_byte1(input logic [7:0] b);
        rx1 = b;
        nrx1 = 1'b1;
        tick();
        nrx1 = 1'b0;
    endtask

    task automatic wait_tx1(input int n);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (txq1.size() >= n) break;
        end
        check("tx_count_reached", 32'(txq1.size() >= n), 32'd1);
    endtask

    task automatic wait_clr1();
        for (int i = 0; i < 200; i++) begin
            tick();
            if (clr1) break;
        end
        check("ram_clr_seen", 32'(clr1), 32'd1);
    endtask

    logic [7:0] exp1 [10] = '{8'h41, 8'h42, 8'h43, 8'h63, 8'h64,
                              8'h65, 8'h66, 8'h67, 8'h0D, 8'h0A};
    logic [7:0] exp3 [10] = '{8'h21, 8'h22, 8'h23, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h0D, 8'h0A};
    logic [7:0] exp2 [4]  = '{8'hFF, 8'h11, 8'h22, 8'h33};

    initial begin
        repeat (2) tick();
        check("reset_outs_1",
              {3'b0, wen1, wa1, wd1, clr1, ra1, tx1, ntx1, busy1, ovr1},
              32'd0);
        check("reset_outs_2",
              {3'b0, wen2, wa2, wd2, clr2, ra2, tx2, ntx2, busy2, ovr2},
              32'd0);
        rst = 1'b1;
        tick();

        // message 1: three bytes, 10 cycles apart
        rx_byte1(8'h41);
        check("wr0", {23'd0, wen1, wa1, wd1}, {23'd0, 1'b1, 4'd0, 8'h41});
        check("busy_after_wr0", 32'(busy1), 32'd0);
        repeat (9) tick();
        rx_byte1(8'h42);
        check("wr1", {23'd0, wen1, wa1, wd1}, {23'd0, 1'b1, 4'd1, 8'h42});
        repeat (9) tick();
        rx_byte1(8'h43);
        check("wr2", {23'd0, wen1, wa1, wd1}, {23'd0, 1'b1, 4'd2, 8'h43});
        check("busy_after_wr2", 32'(busy1), 32'd1);
        tick();
        check("fetch_addr0", {27'd0, ra1, ntx1}, {27'd0, 4'd0, 1'b0});
        tick();
        check("no_strobe_in_wait", 32'(ntx1), 32'd0);
        tick();
        check("first_strobe", {23'd0, ntx1, tx1}, {23'd0, 1'b1, 8'h41});

        // backpressure before char 3, with an rx byte dropped meanwhile
        wait_tx1(2);
        tick();
        txb1 = 1'b1;
        repeat (4) tick();
        rx_byte1(8'h55);
        check("overrun_no_write", 32'(wen1), 32'd0);
        check("overrun_set", 32'(ovr1), 32'd1);
        repeat (15) tick();
        check("held_while_busy", 32'(txq1.size()), 32'd2);
        txb1 = 1'b0;
        tick();
        check("strobe_after_busy", {23'd0, ntx1, tx1}, {23'd0, 1'b1, 8'h43});

        wait_clr1();
        check("idle_after_clr", {27'd0, busy1, ra1}, 32'd0);
        tick();
        check("clr_one_cycle", 32'(clr1), 32'd0);
        @(negedge clk);
        #1;
        check("msg1_tx_count", 32'(txq1.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < txq1.size()) check("msg1_byte", 32'(txq1[i]), 32'(exp1[i]));
        end
        for (int i = 0; i < 8; i++) begin
            if (i < rdq1.size()) check("msg1_rd_addr", 32'(rdq1[i]), 32'(i));
        end
        check("msg1_clr_count", 32'(clrs1), 32'd1);
        tick();

        // message 2 abandoned by reset during char 4
        rx_byte1(8'h31);
        tick();
        rx_byte1(8'h32);
        tick();
        rx_byte1(8'h33);
        wait_tx1(14);
        check("overrun_sticky", 32'(ovr1), 32'd1);
        rst = 1'b0;
        tick();
        check("reset_mid_send",
              {3'b0, wen1, wa1, wd1, clr1, ra1, tx1, ntx1, busy1, ovr1},
              32'd0);
        rst = 1'b1;
        tick();
        txq1.delete();
        rdq1.delete();

        // message 3 after reset: writes restart at addr 0
        rx_byte1(8'h21);
        check("m3_wr0", {23'd0, wen1, wa1, wd1}, {23'd0, 1'b1, 4'd0, 8'h21});
        tick();
        rx_byte1(8'h22);
        check("m3_wr1", {23'd0, wen1, wa1, wd1}, {23'd0, 1'b1, 4'd1, 8'h22});
        tick();
        rx_byte1(8'h23);
        check("m3_wr2", {23'd0, wen1, wa1, wd1}, {23'd0, 1'b1, 4'd2, 8'h23});
        wait_clr1();
        @(negedge clk);
        #1;
        check("msg3_tx_count", 32'(txq1.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < txq1.size()) check("msg3_byte", 32'(txq1[i]), 32'(exp3[i]));
        end
        check("total_clr_count", 32'(clrs1), 32'd2);
        check("overrun_cleared", 32'(ovr1), 32'd0);

        // second build: one byte, four chars, no CR/LF
        tick();
        rx2 = 8'hFF;
        nrx2 = 1'b1;
        tick();
        nrx2 = 1'b0;
        check("d2_wr", {23'd0, wen2, wa2, wd2}, {23'd0, 1'b1, 4'd0, 8'hFF});
        check("d2_busy", 32'(busy2), 32'd1);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (clr2) break;
        end
        check("d2_clr_seen", 32'(clr2), 32'd1);
        @(negedge clk);
        #1;
        check("d2_tx_count", 32'(txq2.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < txq2.size()) check("d2_byte", 32'(txq2[i]), 32'(exp2[i]));
        end
        check("d2_clr_count", 32'(clrs2), 32'd1);
        check("d2_overrun", 32'(ovr2), 32'd0);
        repeat (5) tick();
        check("strobe_spacing", 32'(space_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
